// File: rtl/cpu_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between CPU inst-fetch and data reads.
// Latency: AR accepted in cycle N is issued on m_ar* in N+1; R beats pass through combinationally.
// Backpressure: one burst in flight; requesters see arready only in IDLE, R backpressure is forwarded.
module cpu_axi_rd_arbiter #(
    parameter logic [31:0] ADDR_OFFSET = 32'h40000000,
    parameter int          LEN_W       = 8
) (
    input  logic             cpu_clk,
    input  logic             cpu_reset_n,

    input  logic             inst_arvalid,
    output logic             inst_arready,
    input  logic [31:0]      inst_araddr,
    input  logic [LEN_W-1:0] inst_arlen,
    input  logic [2:0]       inst_arsize,
    input  logic [1:0]       inst_arburst,
    output logic             inst_rvalid,
    input  logic             inst_rready,
    output logic [31:0]      inst_rdata,
    output logic [1:0]       inst_rresp,
    output logic             inst_rlast,

    input  logic             mem_arvalid,
    output logic             mem_arready,
    input  logic [31:0]      mem_araddr,
    input  logic [LEN_W-1:0] mem_arlen,
    input  logic [2:0]       mem_arsize,
    input  logic [1:0]       mem_arburst,
    output logic             mem_rvalid,
    input  logic             mem_rready,
    output logic [31:0]      mem_rdata,
    output logic [1:0]       mem_rresp,
    output logic             mem_rlast,

    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [31:0]      m_araddr,
    output logic [LEN_W-1:0] m_arlen,
    output logic [2:0]       m_arsize,
    output logic [1:0]       m_arburst,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rlast,

    output logic             len_err
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t           r_state;
    logic             r_prio;       // 0 = inst preferred, 1 = mem preferred
    logic             r_gnt;        // 0 = inst owns the burst, 1 = mem
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_len_err;
    logic             r_m_arvalid;
    logic [31:0]      r_m_araddr;
    logic [LEN_W-1:0] r_m_arlen;
    logic [2:0]       r_m_arsize;
    logic [1:0]       r_m_arburst;

    logic             w_idle;
    logic             w_sel_inst;
    logic             w_sel_mem;
    logic             w_ar_acc;
    logic             w_in_r;
    logic             w_r_inst;
    logic             w_r_mem;
    logic             w_r_hs;
    logic [31:0]      w_araddr;
    logic [LEN_W-1:0] w_arlen;
    logic [2:0]       w_arsize;
    logic [1:0]       w_arburst;

    // Gating with reset keeps arready low while reset is held, even with arvalid high.
    assign w_idle     = (r_state == S_IDLE) & cpu_reset_n;
    assign w_sel_inst = inst_arvalid & (~mem_arvalid | ~r_prio);
    assign w_sel_mem  = mem_arvalid & ~w_sel_inst;
    assign w_ar_acc   = w_idle & (inst_arvalid | mem_arvalid);

    assign inst_arready = w_idle & w_sel_inst;
    assign mem_arready  = w_idle & w_sel_mem;

    assign w_araddr  = w_sel_mem ? mem_araddr  : inst_araddr;
    assign w_arlen   = w_sel_mem ? mem_arlen   : inst_arlen;
    assign w_arsize  = w_sel_mem ? mem_arsize  : inst_arsize;
    assign w_arburst = w_sel_mem ? mem_arburst : inst_arburst;

    assign w_in_r   = (r_state == S_R);
    assign w_r_inst = w_in_r & ~r_gnt;
    assign w_r_mem  = w_in_r & r_gnt;
    assign m_rready = (w_r_inst & inst_rready) | (w_r_mem & mem_rready);
    assign w_r_hs   = m_rvalid & m_rready;

    assign inst_rvalid = w_r_inst & m_rvalid;
    assign inst_rdata  = w_r_inst ? m_rdata : 32'd0;
    assign inst_rresp  = w_r_inst ? m_rresp : 2'd0;
    assign inst_rlast  = w_r_inst & m_rlast;
    assign mem_rvalid  = w_r_mem & m_rvalid;
    assign mem_rdata   = w_r_mem ? m_rdata : 32'd0;
    assign mem_rresp   = w_r_mem ? m_rresp : 2'd0;
    assign mem_rlast   = w_r_mem & m_rlast;

    assign m_arvalid = r_m_arvalid;
    assign m_araddr  = r_m_araddr;
    assign m_arlen   = r_m_arlen;
    assign m_arsize  = r_m_arsize;
    assign m_arburst = r_m_arburst;
    assign len_err   = r_len_err;

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_beat_cnt  <= '0;
            r_len_err   <= 1'b0;
            r_m_arvalid <= 1'b0;
            r_m_araddr  <= 32'd0;
            r_m_arlen   <= '0;
            r_m_arsize  <= 3'd0;
            r_m_arburst <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ar_acc) begin
                        r_gnt       <= w_sel_mem;
                        r_m_araddr  <= w_araddr + ADDR_OFFSET;
                        r_m_arlen   <= w_arlen;
                        r_m_arsize  <= w_arsize;
                        r_m_arburst <= w_arburst;
                        r_m_arvalid <= 1'b1;
                        r_beat_cnt  <= '0;
                        r_state     <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        r_m_arvalid <= 1'b0;
                        r_state     <= S_R;
                    end
                end
                S_R: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
                        if (m_rlast) begin
                            if (r_beat_cnt != r_m_arlen) r_len_err <= 1'b1;
                            r_prio  <= ~r_gnt;
                            r_state <= S_IDLE;
                        end else if (r_beat_cnt == r_m_arlen) begin
                            // Overrun: keep draining until the memory side ends the burst.
                            r_len_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_rd_arbiter.sv
// Scoreboard bench for cpu_axi_rd_arbiter: requester and memory models plus a negedge monitor.
module tb_cpu_axi_rd_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_reset_n;
    logic        inst_arvalid, inst_arready, inst_rvalid, inst_rready, inst_rlast;
    logic [31:0] inst_araddr, inst_rdata;
    logic [7:0]  inst_arlen;
    logic [2:0]  inst_arsize;
    logic [1:0]  inst_arburst, inst_rresp;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
    logic [31:0] mem_araddr, mem_rdata;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst, mem_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        len_err;

    cpu_axi_rd_arbiter #(.ADDR_OFFSET(32'h40000000), .LEN_W(8)) dut (
        .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
        .inst_arvalid(inst_arvalid), .inst_arready(inst_arready), .inst_araddr(inst_araddr),
        .inst_arlen(inst_arlen), .inst_arsize(inst_arsize), .inst_arburst(inst_arburst),
        .inst_rvalid(inst_rvalid), .inst_rready(inst_rready), .inst_rdata(inst_rdata),
        .inst_rresp(inst_rresp), .inst_rlast(inst_rlast),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .len_err(len_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard queues: grant ids (0 inst, 1 mem), issued addresses, R beats {side, data}.
    logic [63:0] exp_gnt_q[$];
    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_beat_q[$];

    // Stimulus configuration.
    int          inst_todo = 0, mem_todo = 0;
    logic [31:0] inst_addr_cfg = 0, mem_addr_cfg = 0;
    logic [7:0]  inst_len_cfg = 0, mem_len_cfg = 0;
    logic        inst_rdy_en = 1'b1, mem_toggle = 1'b0;
    int          ar_stall = 0, early_last = -1;
    logic [31:0] data_base = 0;

    // Handshake flags captured at negedge for the models.
    logic        inst_acc_q = 0, mem_acc_q = 0, ar_hs_q = 0, r_hs_q = 0, r_last_q = 0;
    logic [7:0]  arlen_q = 0;
    int          cyc = 0, rlast_cyc = 0, turn_gap = -1;
    logic        mem_rv_seen = 0;

    always @(negedge cpu_clk) begin
        cyc++;
        inst_acc_q = 0; mem_acc_q = 0; ar_hs_q = 0; r_hs_q = 0; r_last_q = 0;
        if (cpu_reset_n) begin
            inst_acc_q = inst_arvalid & inst_arready;
            mem_acc_q  = mem_arvalid & mem_arready;
            ar_hs_q    = m_arvalid & m_arready;
            r_hs_q     = m_rvalid & m_rready;
            r_last_q   = m_rlast;
            arlen_q    = m_arlen;
            if (mem_rvalid) mem_rv_seen = 1;
            if (inst_acc_q) begin
                turn_gap = cyc - rlast_cyc;
                if (mem_arvalid) chk("loser_mem_arready", {63'd0, mem_arready}, 64'd0);
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'd0, 64'd1);
                else chk("gnt_id", 64'd0, exp_gnt_q.pop_front());
            end
            if (mem_acc_q) begin
                if (inst_arvalid) chk("loser_inst_arready", {63'd0, inst_arready}, 64'd0);
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'd1, 64'd0);
                else chk("gnt_id", 64'd1, exp_gnt_q.pop_front());
            end
            if (ar_hs_q) begin
                if (exp_addr_q.size() == 0) chk("ar_unexpected", {32'd0, m_araddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("m_araddr", {32'd0, m_araddr}, exp_addr_q.pop_front());
            end
            if (inst_rvalid && inst_rready) begin
                if (exp_beat_q.size() == 0) chk("beat_unexpected", {32'd0, inst_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("inst_beat", {32'd0, inst_rdata}, exp_beat_q.pop_front());
            end
            if (mem_rvalid && mem_rready) begin
                if (exp_beat_q.size() == 0) chk("beat_unexpected", {32'd1, mem_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("mem_beat", {32'd1, mem_rdata}, exp_beat_q.pop_front());
            end
            if (r_hs_q && m_rlast) rlast_cyc = cyc;
        end
    end

    // Inst requester: holds arvalid until accepted, then issues the next pending request.
    initial begin
        inst_arvalid = 0; inst_araddr = 0; inst_arlen = 0; inst_arsize = 0; inst_arburst = 0;
        inst_rready = 1;
        forever begin
            @(posedge cpu_clk); #1;
            if (!cpu_reset_n) inst_arvalid = 0;
            else begin
                if (inst_acc_q) inst_arvalid = 0;
                if (!inst_arvalid && inst_todo > 0) begin
                    inst_arvalid = 1; inst_araddr = inst_addr_cfg; inst_arlen = inst_len_cfg;
                    inst_arsize = 3'd2; inst_arburst = 2'd1; inst_todo--;
                end
            end
            inst_rready = inst_rdy_en;
        end
    end

    // Mem requester: optionally toggles rready every cycle.
    initial begin
        mem_arvalid = 0; mem_araddr = 0; mem_arlen = 0; mem_arsize = 0; mem_arburst = 0;
        mem_rready = 1;
        forever begin
            @(posedge cpu_clk); #1;
            if (!cpu_reset_n) mem_arvalid = 0;
            else begin
                if (mem_acc_q) mem_arvalid = 0;
                if (!mem_arvalid && mem_todo > 0) begin
                    mem_arvalid = 1; mem_araddr = mem_addr_cfg; mem_arlen = mem_len_cfg;
                    mem_arsize = 3'd2; mem_arburst = 2'd1; mem_todo--;
                end
            end
            mem_rready = mem_toggle ? ~mem_rready : 1'b1;
        end
    end

    // Memory model: beat i of a burst carries data_base + i.
    initial begin
        int s_busy, s_len, s_beat;
        s_busy = 0; s_len = 0; s_beat = 0;
        m_arready = 1; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
        forever begin
            @(posedge cpu_clk); #1;
            if (!cpu_reset_n) begin
                s_busy = 0; s_beat = 0; m_arready = 1;
            end else begin
                if (r_hs_q) begin
                    if (r_last_q) s_busy = 0;
                    else s_beat++;
                end
                if (ar_hs_q) begin s_busy = 1; s_len = int'(arlen_q); s_beat = 0; end
                if (m_arvalid && ar_stall > 0) begin m_arready = 0; ar_stall--; end
                else m_arready = 1;
            end
            m_rvalid = (s_busy != 0);
            m_rdata  = data_base + s_beat;
            m_rlast  = (s_busy != 0) && ((early_last >= 0) ? (s_beat == early_last) : (s_beat == s_len));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_beat_q.size() != 0 || exp_gnt_q.size() != 0 || inst_todo != 0 ||
                mem_todo != 0 || inst_arvalid || mem_arvalid) && n < 2000) begin
            @(negedge cpu_clk); n++;
        end
        chk("idle_in_time", {63'd0, n < 2000}, 64'd1);
        repeat (3) @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        cpu_reset_n = 0;
        repeat (3) @(negedge cpu_clk);
        cpu_reset_n = 1;
        @(negedge cpu_clk);
    endtask

    initial begin
        int n;
        cpu_reset_n = 0;
        @(negedge cpu_clk);
        chk("rst_ctrl", {57'd0, m_arvalid, m_rready, inst_arready, mem_arready, inst_rvalid, mem_rvalid, len_err}, 64'd0);
        chk("rst_payload", {19'd0, m_araddr, m_arlen, m_arsize, m_arburst}, 64'd0);
        repeat (2) @(negedge cpu_clk);
        cpu_reset_n = 1;
        @(negedge cpu_clk);

        // Single inst beat, latency and routing.
        data_base = 32'hDEADBEEF; inst_addr_cfg = 32'h100; inst_len_cfg = 0; mem_rv_seen = 0;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40000100);
        exp_beat_q.push_back({32'd0, 32'hDEADBEEF});
        inst_todo = 1;
        n = 0;
        while (!(inst_arvalid && inst_arready) && n < 50) begin @(negedge cpu_clk); n++; end
        chk("t1_acc_in_time", {63'd0, n < 50}, 64'd1);
        chk("t1_arvalid_N", {63'd0, m_arvalid}, 64'd0);
        @(negedge cpu_clk);
        chk("t1_arvalid_N1", {63'd0, m_arvalid}, 64'd1);
        wait_idle();
        chk("t1_mem_rvalid_quiet", {63'd0, mem_rv_seen}, 64'd0);

        // Dual requests from reset alternate inst/mem.
        do_reset();
        data_base = 32'h55; inst_addr_cfg = 32'h200; mem_addr_cfg = 32'h300;
        for (int i = 0; i < 3; i++) begin
            exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40000200); exp_beat_q.push_back({32'd0, 32'h55});
            exp_gnt_q.push_back(1); exp_addr_q.push_back(64'h40000300); exp_beat_q.push_back({32'd1, 32'h55});
        end
        inst_todo = 3; mem_todo = 3;
        wait_idle();

        // mem 4-beat burst with toggling rready; inst arrives mid-burst.
        data_base = 32'hA; mem_len_cfg = 3; mem_toggle = 1; mem_addr_cfg = 32'h1000;
        exp_gnt_q.push_back(1); exp_addr_q.push_back(64'h40001000);
        for (int i = 0; i < 4; i++) exp_beat_q.push_back({32'd1, 32'hA + i});
        mem_todo = 1;
        n = 0;
        while (exp_gnt_q.size() != 0 && n < 50) begin @(negedge cpu_clk); n++; end
        inst_addr_cfg = 32'h2000; inst_len_cfg = 0;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40002000); exp_beat_q.push_back({32'd0, 32'hA});
        inst_todo = 1;
        wait_idle();
        chk("t3_turnaround", turn_gap, 64'd1);
        mem_toggle = 0;

        // AR stall: payload held stable.
        data_base = 32'h100; ar_stall = 10; inst_addr_cfg = 32'h400; inst_len_cfg = 1;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40000400);
        exp_beat_q.push_back({32'd0, 32'h100}); exp_beat_q.push_back({32'd0, 32'h101});
        inst_todo = 1;
        n = 0;
        while (!m_arvalid && n < 50) begin @(negedge cpu_clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("t4_ar_hold", {19'd0, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst},
                {19'd0, 1'b1, 32'h40000400, 8'd1, 3'd2, 2'd1});
            @(negedge cpu_clk);
        end
        wait_idle();
        chk("t5_len_err_pre", {63'd0, len_err}, 64'd0);

        // Short burst: rlast on 3rd beat of a len=3 request.
        data_base = 32'h20; early_last = 2; mem_len_cfg = 3; mem_addr_cfg = 32'h500;
        exp_gnt_q.push_back(1); exp_addr_q.push_back(64'h40000500);
        for (int i = 0; i < 3; i++) exp_beat_q.push_back({32'd1, 32'h20 + i});
        mem_todo = 1;
        wait_idle();
        early_last = -1;
        chk("t5_len_err_set", {63'd0, len_err}, 64'd1);
        inst_addr_cfg = 32'h600; inst_len_cfg = 0;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40000600); exp_beat_q.push_back({32'd0, 32'h20});
        inst_todo = 1;
        wait_idle();
        chk("t5_len_err_sticky", {63'd0, len_err}, 64'd1);

        // Address wrap, then reset in R.
        data_base = 32'h30; inst_rdy_en = 0; inst_addr_cfg = 32'hC0000004; inst_len_cfg = 3;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h00000004);
        inst_todo = 1;
        n = 0;
        while (exp_addr_q.size() != 0 && n < 50) begin @(negedge cpu_clk); n++; end
        @(negedge cpu_clk);
        chk("t6_in_r", {63'd0, inst_rvalid}, 64'd1);
        #2 cpu_reset_n = 0;
        #1;
        chk("t6_rst_ctrl", {57'd0, m_arvalid, m_rready, inst_arready, mem_arready, inst_rvalid, mem_rvalid, len_err}, 64'd0);
        chk("t6_rst_payload", {inst_rdata, m_araddr}, 64'd0);
        repeat (3) @(negedge cpu_clk);
        inst_rdy_en = 1;
        cpu_reset_n = 1;
        @(negedge cpu_clk);

        data_base = 32'h40; inst_addr_cfg = 32'h10; inst_len_cfg = 0; mem_addr_cfg = 32'h20; mem_len_cfg = 0;
        exp_gnt_q.push_back(0); exp_addr_q.push_back(64'h40000010); exp_beat_q.push_back({32'd0, 32'h40});
        exp_gnt_q.push_back(1); exp_addr_q.push_back(64'h40000020); exp_beat_q.push_back({32'd1, 32'h40});
        inst_todo = 1; mem_todo = 1;
        wait_idle();
        chk("final_queues_empty", exp_addr_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
